// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, symmetric debouncer and edge detector for
// asynchronous board inputs (buttons, switches). All logic lives in the clk_i domain.
//
// Ports:
//   clk_i      - clock, all state on the rising edge
//   rst_ni     - asynchronous active-low reset
//   in_i       - raw asynchronous inputs, one bit per channel
//   level_o    - debounced level per channel
//   press_o    - one-cycle pulse on each debounced 0->1 edge (and on each auto-repeat)
//   release_o  - one-cycle pulse on each debounced 1->0 edge
//
// Optional feature macro: INPUT_CONDITIONER_REPEAT_EN
//   When defined, a channel held high emits a press pulse after REPEAT_DELAY sample ticks and
//   then every REPEAT_PERIOD ticks until it is released. When undefined, no repeat logic is
//   built and press fires only on the debounced rising edge.

module input_conditioner #(
   parameter int unsigned WIDTH          = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned SAMPLE_CNT_MAX = 29411,
   parameter int unsigned PULSE_CNT_MAX  = 200,
   parameter int unsigned REPEAT_DELAY   = 1000,
   parameter int unsigned REPEAT_PERIOD  = 200
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] press_o,
   output logic [WIDTH-1:0] release_o
);

   // A one-cycle sample period still needs a 1-bit counter register.
   localparam int unsigned TickW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
   localparam int unsigned DbW   = $clog2(PULSE_CNT_MAX + 1);

   // Reject configurations the counters cannot represent.
   if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("input_conditioner: invalid parameter set");
   end

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;

   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick;

   logic [DbW-1:0]   db_cnt_q [WIDTH];
   logic [DbW-1:0]   db_cnt_d [WIDTH];

   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] press_q, press_d;
   logic [WIDTH-1:0] release_q, release_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Shared sample tick: counts 0..SAMPLE_CNT_MAX-1 and strobes on the last count.
   always_comb begin
      tick       = (tick_cnt_q == TickW'(SAMPLE_CNT_MAX - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   // Debounce: a match clears progress immediately; mismatching ticks accumulate until the
   // level flips on the PULSE_CNT_MAX-th consecutive one.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (s[i] == level_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (tick) begin
            if (db_cnt_q[i] == DbW'(PULSE_CNT_MAX - 1)) begin
               db_cnt_d[i] = '0;
               level_d[i]  = ~level_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef INPUT_CONDITIONER_REPEAT_EN
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RepW   = $clog2(RepMax + 1);

   logic [RepW-1:0]  rep_cnt_q [WIDTH];
   logic [RepW-1:0]  rep_cnt_d [WIDTH];
   // 0 while waiting out the initial delay, 1 once in periodic repeat.
   logic [WIDTH-1:0] rep_period_q, rep_period_d;
   logic [WIDTH-1:0] rep_fire;
   logic [RepW-1:0]  rep_target;

   // Only counts while the level is and stays high, so a repeat can never coincide with
   // the press edge or with release.
   always_comb begin
      rep_cnt_d    = rep_cnt_q;
      rep_period_d = rep_period_q;
      rep_fire     = '0;
      rep_target   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rep_target = rep_period_q[i] ? RepW'(REPEAT_PERIOD - 1) : RepW'(REPEAT_DELAY - 1);
         if (!level_q[i] || !level_d[i]) begin
            rep_cnt_d[i]    = '0;
            rep_period_d[i] = 1'b0;
         end else if (tick) begin
            if (rep_cnt_q[i] == rep_target) begin
               rep_fire[i]     = 1'b1;
               rep_cnt_d[i]    = '0;
               rep_period_d[i] = 1'b1;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      press_d   = (level_d & ~level_q) | rep_fire;
      release_d = ~level_d & level_q;
   end
`else
   always_comb begin
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         for (int i = 0; i < WIDTH; i++) begin
            db_cnt_q[i] <= '0;
         end
         tick_cnt_q <= '0;
         level_q    <= '0;
         press_q    <= '0;
         release_q  <= '0;
`ifdef INPUT_CONDITIONER_REPEAT_EN
         for (int i = 0; i < WIDTH; i++) begin
            rep_cnt_q[i] <= '0;
         end
         rep_period_q <= '0;
`endif
      end else begin
         sync_q[0] <= in_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         tick_cnt_q <= tick_cnt_d;
         db_cnt_q   <= db_cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
`ifdef INPUT_CONDITIONER_REPEAT_EN
         rep_cnt_q    <= rep_cnt_d;
         rep_period_q <= rep_period_d;
`endif
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner.
//   u_dut: WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, REPEAT_DELAY=5,
//          REPEAT_PERIOD=2. Directed phases push expected press/release events (with latency
//          windows) to a queue; a negedge monitor pops one per observed pulse.
//   u_deg: SAMPLE_CNT_MAX=1, PULSE_CNT_MAX=1 with random input every cycle; each driven value
//          is queued and must appear on level exactly SYNC_STAGES+1 cycles later.

module tb_input_conditioner;

   logic       clk;
   logic       rst_n, rst_n_deg;
   logic [1:0] in_m, lvl_m, prs_m, rel_m;
   logic [1:0] in_d, lvl_d, prs_d, rel_d;

   input_conditioner #(
      .WIDTH(2), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3),
      .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .in_i(in_m),
      .level_o(lvl_m), .press_o(prs_m), .release_o(rel_m)
   );

   input_conditioner #(
      .WIDTH(2), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1),
      .REPEAT_DELAY(1000), .REPEAT_PERIOD(200)
   ) u_deg (
      .clk_i(clk), .rst_ni(rst_n_deg), .in_i(in_d),
      .level_o(lvl_d), .press_o(prs_d), .release_o(rel_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit is_press;
      int ch;
      int base;
      int lo;
      int hi;
      bit rel;   // window measured from the previous observed event instead of base
   } evt_t;

   evt_t       evq[$];
   logic [1:0] dq[$];
   logic [1:0] deg_prev = 2'b00;
   int         last_evt_cyc = 0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_evt(input bit is_press, input int ch, input int base, input int lo,
                             input int hi, input bit rel);
      evt_t e;
      e.is_press = is_press;
      e.ch       = ch;
      e.base     = base;
      e.lo       = lo;
      e.hi       = hi;
      e.rel      = rel;
      evq.push_back(e);
   endtask

   task automatic handle(input bit is_press, input int ch);
      evt_t e;
      int   lat;
      if (evq.size() == 0) begin
         chk($sformatf("spurious_%s%0d", is_press ? "press" : "release", ch), 1, 0);
      end else begin
         e = evq.pop_front();
         chk("evt_id", is_press ? 100 + ch : 200 + ch, e.is_press ? 100 + e.ch : 200 + e.ch);
         lat = cyc - (e.rel ? last_evt_cyc : e.base);
         chk($sformatf("evt_lat_%s%0d lat=%0d window=%0d..%0d", e.is_press ? "press" : "release",
                       e.ch, lat, e.lo, e.hi), (lat >= e.lo && lat <= e.hi), 1);
      end
      last_evt_cyc = cyc;
   endtask

   // Pulse monitor for the main instance.
   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (prs_m[c] === 1'b1) handle(1'b1, c);
         if (rel_m[c] === 1'b1) handle(1'b0, c);
      end
   end

   // Degenerate instance: level is the input delayed by 3 cycles, pulses on every change.
   always @(negedge clk) begin
      logic [1:0] v;
      if (dq.size() >= 4) begin
         v = dq.pop_front();
         chk("deg_level", lvl_d, v);
         chk("deg_press", prs_d, v & ~deg_prev);
         chk("deg_release", rel_d, ~v & deg_prev);
         deg_prev = v;
      end
   end

   initial begin
      in_d      = 2'b00;
      rst_n_deg = 1'b1;
      #1 rst_n_deg = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n_deg = 1'b1;
      forever begin
         in_d = 2'($urandom_range(0, 3));
         dq.push_back(in_d);
         @(posedge clk);
         #1;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; holds reset for one cycle, returns deassertion cycle.
   task automatic pulse_reset(output int r);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_pulse_level", lvl_m, 0);
      chk("rst_pulse_press", prs_m, 0);
      chk("rst_pulse_release", rel_m, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      r = cyc;
   endtask

   initial begin
      int c0;
      int r;
      in_m  = 2'b00;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_level", lvl_m, 0);
      chk("reset_press", prs_m, 0);
      chk("reset_release", rel_m, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(5);

      // Press and hold channel 0 for 80 cycles.
      c0   = cyc;
      in_m = 2'b01;
      expect_evt(1'b1, 0, c0, 11, 14, 1'b0);
`ifdef INPUT_CONDITIONER_REPEAT_EN
      expect_evt(1'b1, 0, 0, 20, 20, 1'b1);
      for (int k = 0; k < 7; k++) expect_evt(1'b1, 0, 0, 8, 8, 1'b1);
`endif
      cycles(40);
      chk("hold_level", lvl_m, 2'b01);
      cycles(40);
      chk("hold_level_late", lvl_m, 2'b01);

      // Release channel 0.
      c0   = cyc;
      in_m = 2'b00;
      expect_evt(1'b0, 0, c0, 11, 14, 1'b0);
      cycles(20);
      chk("release_level", lvl_m, 2'b00);

      // Glitch shorter than the debounce time.
      in_m = 2'b01;
      cycles(6);
      in_m = 2'b00;
      cycles(15);
      chk("glitch_level_mid", lvl_m, 2'b00);
      cycles(15);
      chk("glitch_level", lvl_m, 2'b00);

      // Both channels together, then reset before the release can complete.
      c0   = cyc;
      in_m = 2'b11;
      expect_evt(1'b1, 0, c0, 11, 14, 1'b0);
      expect_evt(1'b1, 1, 0, 0, 0, 1'b1);
      cycles(16);
      chk("both_level", lvl_m, 2'b11);
      in_m = 2'b00;
      cycles(5);
      chk("both_level_predrop", lvl_m, 2'b11);
      cycles(1);
      pulse_reset(r);
      chk("post_reset_level", lvl_m, 2'b00);
      cycles(30);
      chk("post_reset_level_late", lvl_m, 2'b00);

      // Input held through a mid-debounce reset counts as a fresh press.
      in_m = 2'b01;
      cycles(8);
      chk("middeb_level", lvl_m, 2'b00);
      pulse_reset(r);
      expect_evt(1'b1, 0, r, 11, 14, 1'b0);
      cycles(16);
      chk("fresh_press_level", lvl_m, 2'b01);
      c0   = cyc;
      in_m = 2'b00;
      expect_evt(1'b0, 0, c0, 11, 14, 1'b0);
      cycles(20);
      chk("fresh_release_level", lvl_m, 2'b00);

      cycles(2);
      chk("evq_empty", evq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
